// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: decoded instruction, scoreboard entry,
// register address and operand forwarding-source encodings.
package issue_queue_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t src0;
    reg_addr_t src1;
    reg_addr_t dest;
    logic      is_load;
    logic      is_mem;
    logic      uses_src0;
    logic      uses_src1;
  } decoded_inst_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] position;
  } sb_data_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // Position a freshly issued result occupies in the scoreboard shift register.
  localparam logic [2:0] POS_ISSUED = 3'b100;

  function automatic fwd_sel_e pos_to_fwd(input logic [2:0] pos);
    if (pos[2])      return FWD_EX;
    else if (pos[1]) return FWD_MEM;
    else if (pos[0]) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/issue_queue_operand_check.sv
// Per-operand readiness and forwarding-source decode from one scoreboard entry.
module operand_check
  import issue_queue_pkg::*;
(
  input  logic       i_uses,
  input  reg_addr_t  i_src,
  input  sb_data_t   i_sb,
  output logic       o_ready,
  output logic [1:0] o_fwd_sel
);

  // A load still in EX has no data to forward yet; every other in-flight value does.
  assign o_ready   = !i_uses || (i_src == '0) || (i_sb.position == 3'b000) ||
                     !(i_sb.is_load && i_sb.position[2]);
  assign o_fwd_sel = pos_to_fwd(i_sb.position);

endmodule

// File: rtl/issue_queue.sv
// Dual-entry in-order issue queue with scoreboard hazard check.
// Define ISSUE_QUEUE_DUAL_ISSUE_EN to allow the second head entry to issue alongside the first.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flash,
  input  logic [1:0]          in_valid,
  input  decoded_inst_t [1:0] in_inst,
  output logic                in_ready,
  output reg_addr_t [3:0]     sb_read_addr,
  input  sb_data_t [3:0]      sb_data,
  output logic [1:0]          sb_write_ena,
  output reg_addr_t [1:0]     sb_write_addr,
  output sb_data_t [1:0]      sb_write_data,
  output logic [1:0]          issue_valid,
  output decoded_inst_t [1:0] issue_inst,
  output logic [3:0][1:0]     fwd_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef ISSUE_QUEUE_DUAL_ISSUE_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  decoded_inst_t       r_mem [DEPTH];
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [1:0]          r_issue_valid_p1;
  decoded_inst_t [1:0] r_issue_inst_p1;
  logic [3:0][1:0]     r_fwd_sel_p1;

  logic [AW-1:0]       w_head_p1;
  logic [AW-1:0]       w_tail_p1;
  decoded_inst_t       w_head0;
  decoded_inst_t       w_head1;
  logic [CW-1:0]       w_free;
  logic                w_h0_vld;
  logic                w_h1_vld;
  logic [3:0]          w_op_use;
  reg_addr_t [3:0]     w_op_src;
  logic [3:0]          w_rdy;
  logic [3:0][1:0]     w_fwd;
  logic                w_raw;
  logic                w_both_mem;
  logic                w_issue0;
  logic                w_issue1;
  logic                w_enq0;
  logic                w_enq1;
  logic [CW-1:0]       w_enq_n;
  logic [CW-1:0]       w_deq_n;

  assign w_head_p1 = r_head + AW'(1);
  assign w_tail_p1 = r_tail + AW'(1);
  assign w_head0   = r_mem[r_head];
  assign w_head1   = r_mem[w_head_p1];

  assign w_free   = CW'(DEPTH) - r_count;
  assign in_ready = (w_free >= CW'(2));
  assign w_h0_vld = (r_count != '0);
  assign w_h1_vld = (r_count >= CW'(2));

  // ---- stage p0: scoreboard lookup and issue decision ----
  assign w_op_src = {w_head1.src1, w_head1.src0, w_head0.src1, w_head0.src0};
  assign w_op_use = {w_head1.uses_src1, w_head1.uses_src0, w_head0.uses_src1, w_head0.uses_src0};
  assign sb_read_addr = w_op_src;

  for (genvar k = 0; k < 4; k++) begin : g_opchk
    operand_check u_operand_check (
      .i_uses    (w_op_use[k]),
      .i_src     (w_op_src[k]),
      .i_sb      (sb_data[k]),
      .o_ready   (w_rdy[k]),
      .o_fwd_sel (w_fwd[k])
    );
  end

  assign w_raw = (w_head0.dest != '0) &&
                 ((w_head1.uses_src0 && (w_head1.src0 == w_head0.dest)) ||
                  (w_head1.uses_src1 && (w_head1.src1 == w_head0.dest)));
  assign w_both_mem = w_head0.is_mem && w_head1.is_mem;

  assign w_issue0 = w_h0_vld && !stall && !flash && w_rdy[0] && w_rdy[1];
  assign w_issue1 = DUAL_EN && w_issue0 && w_h1_vld && w_rdy[2] && w_rdy[3] &&
                    !w_raw && !w_both_mem;

  assign sb_write_ena[0]  = w_issue0 && (w_head0.dest != '0);
  assign sb_write_ena[1]  = w_issue1 && (w_head1.dest != '0);
  assign sb_write_addr[0] = w_head0.dest;
  assign sb_write_addr[1] = w_head1.dest;
  assign sb_write_data[0] = '{is_load: w_head0.is_load, position: POS_ISSUED};
  assign sb_write_data[1] = '{is_load: w_head1.is_load, position: POS_ISSUED};

  assign w_enq0  = in_ready && in_valid[0] && !flash;
  assign w_enq1  = w_enq0 && in_valid[1];
  assign w_enq_n = CW'(w_enq0) + CW'(w_enq1);
  assign w_deq_n = CW'(w_issue0) + CW'(w_issue1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq0) r_mem[r_tail]    <= in_inst[0];
    if (w_enq1) r_mem[w_tail_p1] <= in_inst[1];
  end

  // ---- stage p1: registered issue to execute ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_valid_p1 <= '0;
      r_issue_inst_p1  <= '0;
      r_fwd_sel_p1     <= '0;
    end else if (flash) begin
      r_issue_valid_p1 <= '0;
    end else if (!stall) begin
      r_issue_valid_p1   <= {w_issue1, w_issue0};
      r_issue_inst_p1[0] <= w_head0;
      r_issue_inst_p1[1] <= w_head1;
      r_fwd_sel_p1       <= w_fwd;
    end
  end

  assign issue_valid = r_issue_valid_p1;
  assign issue_inst  = r_issue_inst_p1;
  assign fwd_sel     = r_fwd_sel_p1;

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8: instruction buffer entries; power of 2, at least 4.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  downstream stall; no dequeue, no issue, no scoreboard write.
REQ-005 flash  in  1  pipeline flush; empties the buffer.
REQ-006 in_valid  in  2  per-slot enqueue valid from decode; slot0 is older.
REQ-007 in_inst  in  2xDECODED_INST  decoded instructions, with src0, src1, dest, is_load, is_mem, uses_src0, uses_src1.
REQ-008 in_ready  out  1  buffer accepts up to 2 instructions this cycle.
REQ-009 sb_read_addr  out  4xREG_ADDR  scoreboard read ports: {head1.src1, head1.src0, head0.src1, head0.src0}.
REQ-010 sb_data  in  4xSCORE_BOARD_DATA  scoreboard read data; same cycle as sb_read_addr.
REQ-011 sb_write_ena  out  2  per-slot scoreboard write on issue.
REQ-012 sb_write_addr  out  2xREG_ADDR  dest of issued slot.
REQ-013 sb_write_data  out  2xSCORE_BOARD_DATA  new entry for the issued dest.
REQ-014 issue_valid  out  2  registered issue valid to execute.
REQ-015 issue_inst  out  2xDECODED_INST  registered issued instructions.
REQ-016 fwd_sel  out  4x2  registered operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.

Function
REQ-017 Buffer is a circular FIFO; head/tail pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-018 in_ready = 1 when the registered free count is at least 2; it does not credit same-cycle dequeue.
REQ-019 Enqueue happens when in_ready=1 and in_valid!=0; in_valid=01 writes 1 entry, 11 writes 2 in order; 10 is illegal.
REQ-020 Operand ready when the operand is unused, its src is 0, position==000, or position!=000 and not (is_load and position[2]).
REQ-021 fwd_sel per operand = 00 if position==000, else 01/10/11 for the highest set bit position[2]/[1]/[0].
REQ-022 Head0 issues when it is valid, stall=0, flash=0, and both operands are ready.
REQ-023 Head1 issues only when head0 issues and head1 is valid, both its operands are ready, it does not read head0.dest (head0.dest!=0), and head0/head1 are not both is_mem.
REQ-024 Issue decision, dequeue, and sb_write_* are combinational in the same cycle; issue_valid/issue_inst/fwd_sel register on the next edge.
REQ-025 sb_write_ena[i] = issued[i] and dest!=0; sb_write_data = {is_load, position=100}.
REQ-026 Both issued slots with equal dest: both write, and the scoreboard keeps slot1.
REQ-027 Minimum latency is enqueue at edge N, issue decision in cycle N+1, issue_valid at edge N+2.
REQ-028 Under stall=1: registered issue outputs hold, and the FIFO may still enqueue.
REQ-029 Under flash=1: the FIFO empties, simultaneous enqueue is dropped, issue_valid clears, and sb_write_ena=0; flash beats stall.
REQ-030 Full buffer with simultaneous dequeue: in_ready stays 0 that cycle, and no overflow occurs.

Reset
REQ-031 On rst: head=tail=count=0, issue_valid=00, issue_inst and fwd_sel cleared, in_ready=1, sb_write_ena=00.
REQ-032 Reset asserted mid-operation discards all buffered and in-flight issue state immediately, without waiting for clk.

Configuration
REQ-033 Macro ISSUE_QUEUE_DUAL_ISSUE_EN, when defined, enables REQ-023 dual issue.
REQ-034 Without the macro: slot1 never issues, issue_valid[1]=0, sb_write_ena[1]=0, and ports keep their widths.

Structure
REQ-035 DECODED_INST, SCORE_BOARD_DATA (is_load, position[2:0]), REG_ADDR, and the fwd_sel encodings live in the shared defines package.
REQ-036 Operand readiness and forwarding decode (REQ-020/021) is sub-module operand_check, instantiated 4 times.
REQ-037 The FIFO is inline, and the RTL totals 120-400 lines.

Verification
REQ-038 Single ALU op, src0=r3 with position=000 -> issue_valid=01 two edges after enqueue, fwd_sel=00, sb_write_addr=r(dest), data {0,100}.
REQ-039 Head0 load to r5, head1 reads r5 with scoreboard position 100, is_load=1 -> head1 waits; position 010 the next cycle -> issues with fwd_sel=10.
REQ-040 Two independent ALU ops (macro on) -> issue_valid=11; macro off -> 01 then 01 on consecutive cycles.
REQ-041 Fill DEPTH-1 entries -> in_ready=0; dequeue two -> in_ready returns to 1 the next cycle; pointer wrap keeps order across 3 full passes.
REQ-042 flash with 5 entries buffered and in_valid=11 -> count=0 next edge, issue_valid=00, nothing enqueued.
REQ-043 rst pulse mid-stream between edges -> outputs per REQ-031 immediately, in_ready=1.
